// File: rtl/serdes_rst_pkg.sv
// Shared definitions for the SERDES reset sequencer: FSM state encodings
// and the width rule for the hold / stage-gap / per-channel counters.
package serdes_rst_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Wide enough to hold the larger of the two terminal counts, with one
  // spare bit of headroom so a count can never wrap.
  function automatic int cnt_w(input int hold_cyc, input int stage_gap);
    int m;
    m = (hold_cyc > stage_gap) ? hold_cyc : stage_gap;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/serdes_rst_sync_cell.sv
// Multi-flop synchroniser with an asynchronous preset value. With RST_VAL=1
// it forms a reset synchroniser (async assert, clocked release); with
// RST_VAL=0 it is a plain level synchroniser cleared by reset.
module serdes_rst_sync_cell #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift chain; rst forces every stage to RST_VAL without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/serdes_rst_seq.sv
// SERDES reset sequencer: waits for a stable PLL lock, releases channel
// resets one at a time, then services per-channel soft resets in RUN.
// Optional build macro SERDES_RST_BUFG_EN routes each rst_out bit through
// a BUFG global buffer; otherwise rst_out comes straight from the flops.
module serdes_rst_seq
  import serdes_rst_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pll_lock,
  input  logic           soft_rst,
  input  logic [NCH-1:0] ch_rst_req,
  output logic [NCH-1:0] rst_out,
  output logic           rst_done,
  output logic [1:0]     state
);

  localparam int CW = cnt_w(HOLD_CYC, STAGE_GAP);

  logic                    rst_i;
  logic                    lock_s;
  state_t                  state_q, state_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [3:0]              idx_q, idx_n;
  logic [NCH-1:0]          rst_q, rout_n;
  logic [NCH-1:0][CW-1:0]  ch_cnt_q, ch_cnt_n;
  logic                    done_q, done_n;
  logic                    to_hold;

  serdes_rst_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rst_sync (
    .clk (clk),
    .rst (rst),
    .d   (1'b0),
    .q   (rst_i)
  );

  serdes_rst_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // State and counter registers, held in reset by the synchronised rst_i.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_q    <= '1;
      ch_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      rst_q    <= rout_n;
      ch_cnt_q <= ch_cnt_n;
      done_q   <= done_n;
    end
  end

  // Next-state logic; soft_rst beats lock loss, which beats channel requests.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    rout_n   = rst_q;
    ch_cnt_n = ch_cnt_q;
    done_n   = 1'b0;
    to_hold  = 1'b0;
    if (soft_rst) begin
      to_hold = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          rout_n = '1;
          if (!lock_s) begin
            cnt_n = '0;
          end else if (cnt_q == CW'(HOLD_CYC - 1)) begin
            state_n   = REL;
            cnt_n     = '0;
            idx_n     = 4'd1;
            rout_n[0] = 1'b0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        REL: begin
          if (!lock_s) begin
            to_hold = 1'b1;
          end else if (idx_q == 4'(NCH)) begin
            state_n = RUN;
            done_n  = 1'b1;
          end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
            for (int k = 0; k < NCH; k++) begin
              if (idx_q == 4'(k)) rout_n[k] = 1'b0;
            end
            idx_n = idx_q + 4'd1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            to_hold = 1'b1;
          end else begin
            for (int k = 0; k < NCH; k++) begin
              if (ch_rst_req[k]) begin
                rout_n[k]   = 1'b1;
                ch_cnt_n[k] = CW'(HOLD_CYC - 1);
              end else if (rst_q[k]) begin
                if (ch_cnt_q[k] == '0) rout_n[k] = 1'b0;
                else                   ch_cnt_n[k] = ch_cnt_q[k] - CW'(1);
              end
            end
            // Done drops with a new request and rises one edge after the
            // last channel has come out of reset.
            done_n = ~|rst_q && ~|ch_rst_req;
          end
        end
        default: to_hold = 1'b1;
      endcase
    end
    if (to_hold) begin
      state_n  = HOLD;
      cnt_n    = '0;
      idx_n    = '0;
      rout_n   = '1;
      ch_cnt_n = '0;
      done_n   = 1'b0;
    end
  end

  assign rst_done = done_q;
  assign state    = state_q;

`ifdef SERDES_RST_BUFG_EN
  for (genvar g = 0; g < NCH; g++) begin : g_bufg
    BUFG u_bufg (.I(rst_q[g]), .O(rst_out[g]));
  end
`else
  assign rst_out = rst_q;
`endif

endmodule

// File: tb/tb_serdes_rst_seq.sv
// Directed bench for serdes_rst_seq at default parameters. Edges are
// counted from the rst release; outputs are sampled 1 time unit after each
// rising edge.
module tb_serdes_rst_seq;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       soft_rst;
  logic [3:0] ch_rst_req;
  logic [3:0] rst_out;
  logic       rst_done;
  logic [1:0] state;

  int tests;
  int fails;

  serdes_rst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .soft_rst   (soft_rst),
    .ch_rst_req (ch_rst_req),
    .rst_out    (rst_out),
    .rst_done   (rst_done),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Bring the DUT from reset into RUN with lock held high (43 edges).
  task automatic reach_run();
    pll_lock = 1'b1;
    rst = 1'b1;
    tick();
    release_rst();
    repeat (43) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_lock = 1'b0; soft_rst = 1'b0; ch_rst_req = 4'b0000;
    #1;
    tests++;
    if ({rst_out, rst_done, state} !== 7'b1111_0_00) begin
      fails++;
      $display("FAIL reset_async: got %b %b %0d want 1111 0 0", rst_out, rst_done, state);
    end
    pll_lock = 1'b1;
    repeat (4) tick();
    tests++;
    if ({rst_out, rst_done, state} !== 7'b1111_0_00) begin
      fails++;
      $display("FAIL reset_held: got %b %b %0d want 1111 0 0", rst_out, rst_done, state);
    end
  endtask

  task automatic test_power_up();
    logic [3:0] exp_out;
    logic       exp_done;
    logic [1:0] exp_st;
    pll_lock = 1'b1;
    rst = 1'b1;
    tick();
    release_rst();
    for (int e = 1; e <= 43; e++) begin
      tick();
      for (int k = 0; k < 4; k++) exp_out[k] = (e < 18 + 8 * k);
      exp_done = (e >= 43);
      exp_st   = (e < 18) ? 2'd0 : (e < 43) ? 2'd1 : 2'd2;
      tests++;
      if (rst_out !== exp_out) begin
        fails++;
        $display("FAIL powerup_rst_out edge %0d: got %b want %b", e, rst_out, exp_out);
      end
      tests++;
      if (rst_done !== exp_done) begin
        fails++;
        $display("FAIL powerup_done edge %0d: got %b want %b", e, rst_done, exp_done);
      end
      tests++;
      if (state !== exp_st) begin
        fails++;
        $display("FAIL powerup_state edge %0d: got %0d want %0d", e, state, exp_st);
      end
    end
  endtask

  task automatic test_lock_loss();
    pll_lock = 1'b0;
    tick(); tick();
    tests++;
    if ({rst_out, rst_done, state} !== 7'b0000_1_10) begin
      fails++;
      $display("FAIL lockloss_d2: got %b %b %0d want 0000 1 2", rst_out, rst_done, state);
    end
    tick();
    tests++;
    if ({rst_out, rst_done, state} !== 7'b1111_0_00) begin
      fails++;
      $display("FAIL lockloss_d3: got %b %b %0d want 1111 0 0", rst_out, rst_done, state);
    end
    pll_lock = 1'b1;
    repeat (17) tick();
    tests++;
    if ({rst_out, state} !== 6'b1111_00) begin
      fails++;
      $display("FAIL relock_d20: got %b %0d want 1111 0", rst_out, state);
    end
    tick();
    tests++;
    if ({rst_out, state} !== 6'b1110_01) begin
      fails++;
      $display("FAIL relock_d21: got %b %0d want 1110 1", rst_out, state);
    end
    // Lose lock again while in REL.
    pll_lock = 1'b0;
    tick(); tick();
    tests++;
    if ({rst_out, state} !== 6'b1110_01) begin
      fails++;
      $display("FAIL rel_lockloss_d2: got %b %0d want 1110 1", rst_out, state);
    end
    tick();
    tests++;
    if ({rst_out, rst_done, state} !== 7'b1111_0_00) begin
      fails++;
      $display("FAIL rel_lockloss_d3: got %b %b %0d want 1111 0 0", rst_out, rst_done, state);
    end
    pll_lock = 1'b1;
  endtask

  task automatic test_soft_rst();
    reach_run();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    tests++;
    if ({rst_out, rst_done, state} !== 7'b1111_0_00) begin
      fails++;
      $display("FAIL softrst_E: got %b %b %0d want 1111 0 0", rst_out, rst_done, state);
    end
    repeat (15) tick();
    tests++;
    if ({rst_out, state} !== 6'b1111_00) begin
      fails++;
      $display("FAIL softrst_E15: got %b %0d want 1111 0", rst_out, state);
    end
    tick();
    tests++;
    if ({rst_out, state} !== 6'b1110_01) begin
      fails++;
      $display("FAIL softrst_E16: got %b %0d want 1110 1", rst_out, state);
    end
  endtask

  task automatic test_ch_req();
    reach_run();
    ch_rst_req = 4'b0100;
    tick();
    ch_rst_req = 4'b0000;
    for (int i = 0; i <= 15; i++) begin
      if (i > 0) tick();
      tests++;
      if ({rst_out, rst_done} !== 5'b0100_0) begin
        fails++;
        $display("FAIL chreq_E%0d: got %b %b want 0100 0", i, rst_out, rst_done);
      end
    end
    tick();
    tests++;
    if ({rst_out, rst_done} !== 5'b0000_0) begin
      fails++;
      $display("FAIL chreq_E16: got %b %b want 0000 0", rst_out, rst_done);
    end
    tick();
    tests++;
    if ({rst_out, rst_done, state} !== 7'b0000_1_10) begin
      fails++;
      $display("FAIL chreq_E17: got %b %b %0d want 0000 1 2", rst_out, rst_done, state);
    end
  endtask

  task automatic test_ch_extend();
    ch_rst_req = 4'b0010;
    tick();
    ch_rst_req = 4'b0000;
    repeat (4) tick();
    ch_rst_req = 4'b0010;
    tick();
    ch_rst_req = 4'b0000;
    repeat (15) tick();
    tests++;
    if ({rst_out, rst_done} !== 5'b0010_0) begin
      fails++;
      $display("FAIL extend_E20: got %b %b want 0010 0", rst_out, rst_done);
    end
    tick();
    tests++;
    if (rst_out !== 4'b0000) begin
      fails++;
      $display("FAIL extend_E21: got %b want 0000", rst_out);
    end
    tick();
    tests++;
    if (rst_done !== 1'b1) begin
      fails++;
      $display("FAIL extend_E22_done: got %b want 1", rst_done);
    end
  endtask

  task automatic test_priority();
    soft_rst = 1'b1;
    ch_rst_req = 4'b1111;
    tick();
    soft_rst = 1'b0;
    ch_rst_req = 4'b0000;
    tests++;
    if ({rst_out, rst_done, state} !== 7'b1111_0_00) begin
      fails++;
      $display("FAIL prio_soft_over_req: got %b %b %0d want 1111 0 0", rst_out, rst_done, state);
    end
    repeat (16) tick();
    ch_rst_req = 4'b0001;
    tick();
    ch_rst_req = 4'b0000;
    tests++;
    if ({rst_out, state} !== 6'b1110_01) begin
      fails++;
      $display("FAIL req_ignored_rel: got %b %0d want 1110 1", rst_out, state);
    end
  endtask

  task automatic test_hold_restart();
    pll_lock = 1'b1;
    rst = 1'b1;
    tick();
    release_rst();
    repeat (12) tick();
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    repeat (3) tick();
    tests++;
    if ({rst_out, state} !== 6'b1111_00) begin
      fails++;
      $display("FAIL hold_restart_e18: got %b %0d want 1111 0", rst_out, state);
    end
    repeat (14) tick();
    tests++;
    if ({rst_out, state} !== 6'b1111_00) begin
      fails++;
      $display("FAIL hold_restart_e32: got %b %0d want 1111 0", rst_out, state);
    end
    tick();
    tests++;
    if ({rst_out, state} !== 6'b1110_01) begin
      fails++;
      $display("FAIL hold_restart_e33: got %b %0d want 1110 1", rst_out, state);
    end
  endtask

  task automatic test_rst_mid_rel();
    logic [3:0] exp_out;
    pll_lock = 1'b1;
    rst = 1'b1;
    tick();
    release_rst();
    repeat (30) tick();
    tests++;
    if ({rst_out, state} !== 6'b1100_01) begin
      fails++;
      $display("FAIL midrel_e30: got %b %0d want 1100 1", rst_out, state);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({rst_out, rst_done, state} !== 7'b1111_0_00) begin
      fails++;
      $display("FAIL midrel_async: got %b %b %0d want 1111 0 0", rst_out, rst_done, state);
    end
    release_rst();
    for (int e = 1; e <= 43; e++) begin
      tick();
      for (int k = 0; k < 4; k++) exp_out[k] = (e < 18 + 8 * k);
      tests++;
      if (rst_out !== exp_out) begin
        fails++;
        $display("FAIL replay_rst_out edge %0d: got %b want %b", e, rst_out, exp_out);
      end
    end
    tests++;
    if ({rst_done, state} !== 3'b1_10) begin
      fails++;
      $display("FAIL replay_e43: got %b %0d want 1 2", rst_done, state);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_power_up();
    test_lock_loss();
    test_soft_rst();
    test_ch_req();
    test_ch_extend();
    test_priority();
    test_hold_restart();
    test_rst_mid_rel();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
